mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data bus, alongside the RAM.
- Consumes CPU store traffic (mem_wr_sig, mem_addr, mem_wr_data) in its address window.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on the tx pin.
- Returns status on mem_rd_data so firmware can poll before writing.

---
 rtl/mmio_uart_tx.sv | 114 +++++++++++
 tb/tb_mmio_uart_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO; define UART_TX_PARITY_EN for an even-parity bit
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int CLK_DIV = 16,
   parameter int FIFO_DEPTH = 8
) (
   input logic clk,
   input logic reset,
   input logic mem_wr_sig,
   input logic [31:0] mem_addr,
   input logic [31:0] mem_wr_data,
   output logic [31:0] mem_rd_data,
   output logic sel_hit,
   output logic tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic PAR_EN = 1'b1;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic PAR_EN = 1'b0;
`endif
   state_t state;
   logic [7:0] fifo [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic overflow, parity, full, empty, push, pop, baud_end, wr_data, wr_stat;
   logic [15:0] baud;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic unused_bits;
   assign unused_bits = ^{mem_wr_data[31:8], mem_addr[1:0]};
   assign sel_hit = mem_addr[31:3] == BASE_ADDR[31:3];
   assign wr_data = mem_wr_sig & sel_hit & ~mem_addr[2];
   assign wr_stat = mem_wr_sig & sel_hit & mem_addr[2];
   assign full = count == (AW+1)'(FIFO_DEPTH);
   assign empty = count == '0;
   assign push = wr_data & ~full;
   assign pop = (state == IDLE) & ~empty;
   assign baud_end = baud == BAUD_MAX;
   assign mem_rd_data = (sel_hit & mem_addr[2]) ?
      {16'h0, 8'(count), 3'b0, PAR_EN, overflow, empty, full, state != IDLE} : '0;
   // FIFO storage; stale entries are harmless because pointers and count are reset
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= mem_wr_data[7:0];
   end
   // FIFO pointers, occupancy and sticky overflow flag (push is judged before same-cycle pop)
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
         overflow <= (wr_data & full) ? 1'b1 : (wr_stat & mem_wr_data[3]) ? 1'b0 : overflow;
      end
   end
   // Serialiser FSM with registered tx; baud counter wraps at every bit end and idles at 0
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         tx <= 1'b1;
         baud <= '0;
         bit_idx <= '0;
         shift <= '0;
         parity <= 1'b0;
      end else begin
         baud <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
         case (state)
            IDLE: if (pop) begin
               shift <= fifo[rd_ptr];
               parity <= ^fifo[rd_ptr];
               state <= START;
               tx <= 1'b0;
            end
            START: if (baud_end) begin
               bit_idx <= '0;
               state <= DATA;
               tx <= shift[0];
            end
            DATA: if (baud_end) begin
               shift <= shift >> 1;
               bit_idx <= bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
               state <= (bit_idx == 3'd7) ? PARITY : DATA;
               tx <= (bit_idx == 3'd7) ? parity : shift[1];
`else
               state <= (bit_idx == 3'd7) ? STOP : DATA;
               tx <= (bit_idx == 3'd7) ? 1'b1 : shift[1];
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_end) begin
               state <= STOP;
               tx <= 1'b1;
            end
`endif
            STOP: if (baud_end) begin
               state <= IDLE;
               tx <= 1'b1;
            end
            default: begin
               state <= IDLE;
               tx <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx (default parameters, parity section under UART_TX_PARITY_EN)
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam logic [31:0] PB = 32'h10;
`else
   localparam int NB = 10;
   localparam logic [31:0] PB = 32'h0;
`endif
   localparam int FL = NB * DIV;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mem_wr_sig = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wr_data = '0;
   logic [31:0] mem_rd_data;
   logic sel_hit, tx;
   int vecs = 0;
   int errs = 0;
   mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .mem_wr_sig(mem_wr_sig), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .sel_hit(sel_hit), .tx(tx)
   );
   // 10-unit clock period
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_wr_sig = 1'b1;
      mem_addr = a;
      mem_wr_data = d;
      @(negedge clk);
      mem_wr_sig = 1'b0;
      mem_addr = BASE + 4;
   endtask
   task automatic status(input string tag, input logic [31:0] exp);
      mem_addr = BASE + 4;
      #1;
      chk(tag, mem_rd_data, exp | PB);
   endtask
   task automatic probe(input logic [31:0] a, input logic s, input logic [31:0] rd);
      @(negedge clk);
      mem_addr = a;
      #1;
      chk($sformatf("sel_hit @%h", a), {31'b0, sel_hit}, {31'b0, s});
      chk($sformatf("rd_data @%h", a), mem_rd_data, rd);
   endtask
   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, n, 1);
   endtask
   task automatic frame(input string tag, input logic [7:0] b, input int c0);
      logic [10:0] fv;
      logic [3:0] i;
      fv = {1'b1, (NB == 11) ? ^b : 1'b1, b, 1'b0};
      mem_addr = BASE + 4;
      for (int c = c0; c < FL; c++) begin
         i = 4'(c / DIV);
         chk($sformatf("%s tx c%0d", tag, c), {31'b0, tx}, {31'b0, fv[i]});
         chk($sformatf("%s busy c%0d", tag, c), {31'b0, mem_rd_data[0]}, 32'd1);
         @(negedge clk);
      end
   endtask
   initial begin
      int hi;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset tx", {31'b0, tx}, 32'd1);
      status("reset status", 32'h4);
      probe(32'h0000_0000, 1'b0, 32'h0);
      probe(BASE + 7, 1'b1, 32'h4 | PB);
      probe(BASE + 8, 1'b0, 32'h0);
      probe(BASE - 1, 1'b0, 32'h0);
      probe(BASE, 1'b1, 32'h0);
      @(negedge clk);
      // single byte
      wr(BASE, 32'hFFFF_FF55);
      status("after push", 32'h0100);
      wait_start("single start");
      frame("f55", 8'h55, 0);
      chk("single idle tx", {31'b0, tx}, 32'd1);
      status("single done", 32'h4);
      // burst of 8 on consecutive cycles
      for (int b = 1; b <= 8; b++) wr(BASE, 32'(b));
      status("burst peak", 32'h0701);
      frame("b1", 8'h01, 6);
      for (int b = 2; b <= 8; b++) begin
         wait_start($sformatf("burst gap %0d", b));
         frame($sformatf("b%0d", b), 8'(b), 0);
      end
      status("burst end", 32'h4);
      // overflow while busy
      wr(BASE, 32'h11);
      for (int b = 0; b < 8; b++) wr(BASE, 32'h60 + 32'(b));
      wr(BASE, 32'hAA);
      status("ovf set", 32'h080B);
      wr(BASE + 4, 32'hFFFF_FFF7);
      status("ovf kept", 32'h080B);
      wr(BASE + 4, 32'h8);
      status("ovf clr", 32'h0803);
      frame("o11", 8'h11, 10);
      for (int b = 0; b < 8; b++) begin
         wait_start($sformatf("ovf gap %0d", b));
         frame($sformatf("o6%0d", b), 8'h60 + 8'(b), 0);
      end
      status("ovf drained", 32'h4);
      hi = 0;
      repeat (200) begin
         @(negedge clk);
         hi += int'(tx);
      end
      chk("no AA frame", hi, 200);
      // reset mid-frame
      wr(BASE, 32'h0F);
      wr(BASE, 32'h21);
      wr(BASE, 32'h22);
      repeat (69) @(negedge clk);
      chk("data bit3", {31'b0, tx}, 32'd1);
      status("mid status", 32'h0201);
      reset = 1'b1;
      @(negedge clk);
      chk("reset abort tx", {31'b0, tx}, 32'd1);
      status("reset abort status", 32'h4);
      reset = 1'b0;
      hi = 0;
      repeat (300) begin
         @(negedge clk);
         hi += int'(tx);
      end
      chk("no frame after reset", hi, 300);
      status("after reset idle", 32'h4);
`ifdef UART_TX_PARITY_EN
      wr(BASE, 32'h07);
      wait_start("p07 start");
      frame("p07", 8'h07, 0);
      wr(BASE, 32'h03);
      wait_start("p03 start");
      frame("p03", 8'h03, 0);
      status("parity done", 32'h4);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
